// File: rtl/wb_stage_buf.sv
// Write-back stage: result select, rd=0 suppression, 2-entry skid buffer with
// valid/ready handshake, flush and retirement counter. Optional forwarding ports under WB_BYPASS_EN.
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [1:0]        in_res_sel,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_wb_data,
`ifdef WB_BYPASS_EN
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd2_valid,
  output logic [RD_W-1:0]   fwd2_rd,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e state_q, state_d;

  logic              head_we_q, skid_we_q;
  logic [RD_W-1:0]   head_rd_q, skid_rd_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              cap_we;
  logic [DATA_W-1:0] cap_data;
  logic              accept, pop;

  // Capture-side result mux; reserved select yields a non-writing zero entry.
  always_comb begin
    cap_data = '0;
    case (in_res_sel)
      2'b00:   cap_data = in_alu_res;
      2'b01:   cap_data = in_mem_data;
      2'b10:   cap_data = in_pc_plus4;
      default: cap_data = '0;
    endcase
    cap_we = in_reg_write & (in_rd != '0) & (in_res_sel != 2'b11);
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !pop) state_d = FULL;
                 else if (pop && !accept) state_d = EMPTY;
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_we_q   <= 1'b0;
      head_rd_q   <= '0;
      head_data_q <= '0;
      skid_we_q   <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      head_we_q <= 1'b0;
      skid_we_q <= 1'b0;
    end else begin
      if ((state_q == EMPTY && accept) || (state_q == ONE && accept && pop)) begin
        head_we_q   <= cap_we;
        head_rd_q   <= in_rd;
        head_data_q <= cap_data;
      end else if (state_q == FULL && pop) begin
        head_we_q   <= skid_we_q;
        head_rd_q   <= skid_rd_q;
        head_data_q <= skid_data_q;
      end
      if (state_q == ONE && accept && !pop) begin
        skid_we_q   <= cap_we;
        skid_rd_q   <= in_rd;
        skid_data_q <= cap_data;
      end
    end
  end

  // A pop in a flush cycle still retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt_q <= '0;
    else if (pop && head_we_q)  cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_reg_write = head_we_q;
  assign out_rd        = head_rd_q;
  assign out_wb_data   = head_data_q;
  assign retired_cnt   = cnt_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid  = out_valid & head_we_q;
  assign fwd_rd     = fwd_valid ? head_rd_q : '0;
  assign fwd_data   = fwd_valid ? head_data_q : '0;
  assign fwd2_valid = (state_q == FULL) & skid_we_q;
  assign fwd2_rd    = fwd2_valid ? skid_rd_q : '0;
  assign fwd2_data  = fwd2_valid ? skid_data_q : '0;
`endif

endmodule

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
- Parametrised write-back stage register, successor to the single-entry write-back cycle.
- Selects the final result (ALU / memory / PC+4) and registers it with destination register and write enable.
- Presents the result to the register file through a valid/ready handshake, backed by a 2-entry skid buffer so upstream stalls are not combinational.
- Adds flush, rd=0 write suppression and a retirement counter.

Parameters:
DATA_W, 32, width of result data paths
RD_W, 5, width of destination register index
CNT_W, 16, width of retirement counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  upstream (memory stage) entry valid
in_ready  out  1  stage can accept an entry this cycle
in_reg_write  in  1  entry writes register file
in_res_sel  in  2  result select: 00 ALU, 01 MEM, 10 PC+4, 11 reserved
in_alu_res  in  DATA_W  ALU result
in_mem_data  in  DATA_W  load data
in_pc_plus4  in  DATA_W  link value
in_rd  in  RD_W  destination register
flush  in  1  discard all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  register file / consumer accepts head
out_reg_write  out  1  head write enable
out_rd  out  RD_W  head destination
out_wb_data  out  DATA_W  head write-back data
retired_cnt  out  CNT_W  count of retired register writes

Behaviour:
- Reset (rst=0, asynchronous): both entries invalid; out_valid=0, out_reg_write=0, out_rd=0, out_wb_data=0, in_ready=1, retired_cnt=0. Release is synchronous to the next rising edge.
- Result mux (combinational, at capture): sel 00 -> in_alu_res; 01 -> in_mem_data; 10 -> in_pc_plus4; 11 -> data 0 and write enable forced 0.
- rd=0 rule: captured reg_write = in_reg_write & (in_rd != 0) & (sel != 11).
- Storage: head register (drives out_*) plus skid register. State machine, state held in registers:
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE (head reloads from input); accept & ~pop -> FULL (input into skid); pop & ~accept -> EMPTY.
  - FULL: pop -> ONE (skid moves to head); no accept possible.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (state != FULL). Registered state only; no combinational path from out_ready to in_ready.
- Latency: an entry accepted at edge N is on out_* after edge N when the buffer was EMPTY or popped at N. Throughput is 1 per cycle while out_ready=1.
- Ordering: strictly FIFO; skid entry is never presented before head.
- out_wb_data / out_rd / out_reg_write hold their last value while out_valid=0; the consumer must gate on out_valid & out_reg_write.
- Flush: at next edge state -> EMPTY, out_valid=0, out_reg_write=0. Flush wins over same-cycle accept (input dropped) and over pop (a pop in that cycle still counts if out_ready=1).
- retired_cnt: +1 on pop with out_reg_write=1; wraps 2^CNT_W-1 -> 0; not cleared by flush.
- Reset mid-operation: all entries discarded immediately; no partial write is presented.

Optional Feature:
WB_BYPASS_EN
- Defined: adds outputs fwd_valid (1), fwd_rd (RD_W) and fwd_data (DATA_W), combinationally mirroring the head entry: fwd_valid = out_valid & out_reg_write, for execute-stage forwarding. A second set, fwd2_*, mirrors the skid entry when FULL. Both sets are 0 during reset.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset hold, then release; in_valid=1, sel=00, alu=0xA5A5A5A5, rd=0x0A, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_wb_data=0xA5A5A5A5, out_rd=0x0A; retired_cnt=1 one cycle later.
- sel=01 mem=0x95632214, then sel=10 pc4=0x00000104 back-to-back -> outputs appear in order on consecutive cycles with the correct data.
- out_ready=0 with three entries offered -> in_ready drops after the 2nd accept; the 3rd is held upstream; raising out_ready drains entries 1, 2, 3 in order with no loss or duplication.
- rd=0 with reg_write=1 and sel=11 with rd=5 -> out_reg_write=0 for both; retired_cnt unchanged.
- FULL state, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped; drive rst=0 mid-stream -> outputs go to 0 without waiting for a clock edge.
- Preset 2^CNT_W-1 retirements, then retire one more -> retired_cnt wraps to 0.
